// File: rtl/axi4_lite_master_p_if.sv
// rtl/axi4_lite_master_p_if.sv - command/response and AXI4-Lite bundle for axi4_lite_master_p
`timescale 1ns/1ps

interface axi4_lite_master_p_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_write;
    logic [1:0]            rsp_resp;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  timeout;
    logic [15:0]           err_count;

    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [2:0]            M_AXI_AWPROT;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata, timeout, err_count,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata, timeout, err_count,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_master_p.sv
// rtl/axi4_lite_master_p.sv - single-outstanding AXI4-Lite master with watchdog and error counter
`timescale 1ns/1ps

module axi4_lite_master_p #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rst,
    axi4_lite_master_p_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [32:0] TO_LIMIT = 33'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;

    state_t                state;
    logic                  aw_done, w_done;
    logic                  awvalid, wvalid, bready, arvalid, rready;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  rsp_valid_q, rsp_write_q;
    logic [1:0]            rsp_resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]           err_q;
    logic [31:0]           busy_cnt;
    logic                  aw_hs, w_hs;

    assign aw_hs = awvalid && bus.M_AXI_AWREADY;
    assign w_hs  = wvalid && bus.M_AXI_WREADY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rdata_q     <= '0;
            err_q       <= 16'h0000;
            busy_cnt    <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state != IDLE && busy_cnt != '1)
                busy_cnt <= busy_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q   <= bus.cmd_addr;
                        wdata_q  <= bus.cmd_wdata;
                        wstrb_q  <= bus.cmd_wstrb;
                        busy_cnt <= 32'd0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        if (bus.cmd_write) begin
                            state   <= WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently; either order or the same cycle
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state  <= WRESP;
                        bready <= 1'b1;
                    end
                end
                WRESP: begin
                    if (bus.M_AXI_BVALID) begin
                        bready      <= 1'b0;
                        state       <= IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_resp_q  <= bus.M_AXI_BRESP;
                        if (bus.M_AXI_BRESP != 2'b00 && err_q != 16'hFFFF)
                            err_q <= err_q + 16'd1;
                    end
                end
                RADDR: begin
                    if (bus.M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (bus.M_AXI_RVALID) begin
                        rready      <= 1'b0;
                        state       <= IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_resp_q  <= bus.M_AXI_RRESP;
                        rdata_q     <= bus.M_AXI_RDATA;
                        if (bus.M_AXI_RRESP != 2'b00 && err_q != 16'hFFFF)
                            err_q <= err_q + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy_cnt holds completed busy cycles, so +1 includes the current one
    assign bus.timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                         (({1'b0, busy_cnt} + 33'd1) >= TO_LIMIT);

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.err_count     = err_q;

    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = awvalid;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid;
    assign bus.M_AXI_BREADY  = bready;
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = arvalid;
    assign bus.M_AXI_RREADY  = rready;
endmodule
